// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, saturating stall counter and
// an optional skid buffer enabled by defining PIPE_SKID_EN.
module pipe_stage_reg #(
    parameter int DATA_W     = 272,
    parameter int CTRL_W     = 12,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              r_m_valid;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic [DATA_W-1:0] r_m_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_accept;
    logic              w_drain;

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_m_valid & out_ready;
    assign out_valid = r_m_valid;
    assign out_ctrl  = r_m_ctrl & {CTRL_W{r_m_valid}};
    assign out_data  = r_m_data;
    assign stall_cnt = r_stall_cnt;

`ifdef PIPE_SKID_EN
    logic              r_s_valid;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [DATA_W-1:0] r_s_data;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = ~r_s_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= '0;
            if (CLEAR_DATA != 0) begin
                r_m_data <= '0;
                r_s_data <= '0;
            end
        end else if (!r_m_valid || out_ready) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= r_s_ctrl;
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
                r_s_ctrl  <= '0;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= in_ctrl;
                r_m_data  <= in_data;
            end else begin
                r_m_valid <= 1'b0;
                r_m_ctrl  <= '0;
            end
        end else if (w_accept) begin
            // M is stalled: park the extra beat behind it.
            r_s_valid <= 1'b1;
            r_s_ctrl  <= in_ctrl;
            r_s_data  <= in_data;
        end
    end
`else
    assign in_ready = ~r_m_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            if (CLEAR_DATA != 0) begin
                r_m_data <= '0;
            end
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_ctrl  <= in_ctrl;
            r_m_data  <= in_data;
        end else if (w_drain) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
        end
    end
`endif

    // A squashed cycle is not a stall; clear wins over a coinciding increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !out_ready && !flush) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule
